// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared constants, ALU opcodes and operand-select codes for the execution datapath
package risc_pkg;

   localparam int WIDTH   = 32;
   localparam int NREGS   = 16;
   localparam int AW      = 4;
   localparam int PC_SIZE = 10;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_NOR = 4'd5,
      ALU_NOT = 4'd6,
      ALU_SLL = 4'd7,
      ALU_SRL = 4'd8,
      ALU_SRA = 4'd9,
      ALU_INC = 4'd10,
      ALU_DEC = 4'd11,
      ALU_SLT = 4'd12,
      ALU_SGT = 4'd13,
      ALU_LUI = 4'd14,
      ALU_HAM = 4'd15
   } alu_op_e;

   localparam logic A_SEL_REG = 1'b0;
   localparam logic A_SEL_NPC = 1'b1;
   localparam logic B_SEL_REG = 1'b0;
   localparam logic B_SEL_IMM = 1'b1;

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - register file with two registered read ports and one write port
module regfile_2r1w
   import risc_pkg::*;
#(
   parameter int DW = WIDTH,
   parameter int NR = NREGS
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rd_en1,
   input  logic [AW-1:0] rd_addr1,
   input  logic          rd_en2,
   input  logic [AW-1:0] rd_addr2,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic [DW-1:0] rd_data1,
   output logic [DW-1:0] rd_data2
);

   logic [DW-1:0] regs [NR];

   // Write-first bypass: a read of the register being written returns the new data.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NR; i++) regs[i] <= '0;
         rd_data1 <= '0;
         rd_data2 <= '0;
      end else begin
         if (wr_en) regs[wr_addr] <= wr_data;
         if (rd_en1) rd_data1 <= (wr_en && wr_addr == rd_addr1) ? wr_data : regs[rd_addr1];
         if (rd_en2) rd_data2 <= (wr_en && wr_addr == rd_addr2) ? wr_data : regs[rd_addr2];
      end
   end

endmodule

// File: rtl/risc_exec_datapath.sv
// rtl/risc_exec_datapath.sv - register file, operand muxes and registered 16-op ALU
module risc_exec_datapath
   import risc_pkg::*;
#(
   parameter int WIDTH   = risc_pkg::WIDTH,
   parameter int PC_SIZE = risc_pkg::PC_SIZE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en1,
   input  logic [3:0]         rd_addr1,
   input  logic               rd_en2,
   input  logic [3:0]         rd_addr2,
   input  logic               wr_en,
   input  logic [3:0]         wr_addr,
   input  logic [WIDTH-1:0]   wr_data,
   output logic [WIDTH-1:0]   rd_data1,
   output logic [WIDTH-1:0]   rd_data2,
   input  logic [PC_SIZE-1:0] npc,
   input  logic [WIDTH-1:0]   imm,
   input  logic               a_sel,
   input  logic               b_sel,
   input  logic [3:0]         alu_op,
   output logic [WIDTH-1:0]   alu_result,
   output logic               alu_zero,
   output logic               alu_carry
);

   logic [WIDTH-1:0] op1, op2, res;
   logic [WIDTH:0]   ext;
   logic             carry;
   logic [4:0]       shamt;

   regfile_2r1w #(.DW(WIDTH), .NR(NREGS)) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .rd_en1   (rd_en1),
      .rd_addr1 (rd_addr1),
      .rd_en2   (rd_en2),
      .rd_addr2 (rd_addr2),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data1 (rd_data1),
      .rd_data2 (rd_data2)
   );

   assign op1   = (a_sel == A_SEL_NPC) ? {{(WIDTH-PC_SIZE){1'b0}}, npc} : rd_data1;
   assign op2   = (b_sel == B_SEL_IMM) ? imm : rd_data2;
   assign shamt = op2[4:0];

   // Arithmetic ops go through a WIDTH+1 sum so the top bit is carry (or borrow for subtracts).
   always_comb begin
      res   = '0;
      ext   = '0;
      carry = 1'b0;
      case (alu_op_e'(alu_op))
         ALU_ADD: begin ext = {1'b0, op1} + {1'b0, op2};         res = ext[WIDTH-1:0]; carry = ext[WIDTH]; end
         ALU_SUB: begin ext = {1'b0, op1} - {1'b0, op2};         res = ext[WIDTH-1:0]; carry = ext[WIDTH]; end
         ALU_INC: begin ext = {1'b0, op1} + (WIDTH+1)'(1);       res = ext[WIDTH-1:0]; carry = ext[WIDTH]; end
         ALU_DEC: begin ext = {1'b0, op1} - (WIDTH+1)'(1);       res = ext[WIDTH-1:0]; carry = ext[WIDTH]; end
         ALU_AND: res = op1 & op2;
         ALU_OR:  res = op1 | op2;
         ALU_XOR: res = op1 ^ op2;
         ALU_NOR: res = ~(op1 | op2);
         ALU_NOT: res = ~op1;
         ALU_SLL: res = op1 << shamt;
         ALU_SRL: res = op1 >> shamt;
         ALU_SRA: res = $signed(op1) >>> shamt;
         ALU_SLT: res = WIDTH'($signed(op1) < $signed(op2));
         ALU_SGT: res = WIDTH'($signed(op1) > $signed(op2));
         ALU_LUI: res = op2 << 16;
         ALU_HAM: for (int i = 0; i < WIDTH; i++) res = res + WIDTH'(op1[i]);
         default: res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_result <= '0;
         alu_zero   <= 1'b0;
         alu_carry  <= 1'b0;
      end else begin
         alu_result <= res;
         alu_zero   <= (res == '0);
         alu_carry  <= carry;
      end
   end

endmodule

// File: tb/tb_risc_exec_datapath.sv
// tb/tb_risc_exec_datapath.sv - directed and random checks of risc_exec_datapath against a reference model
module tb_risc_exec_datapath;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en1 = 0, rd_en2 = 0, wr_en = 0, a_sel = 0, b_sel = 0;
   logic [3:0]  rd_addr1 = 0, rd_addr2 = 0, wr_addr = 0, alu_op = 0;
   logic [31:0] wr_data = 0, imm = 0;
   logic [9:0]  npc = 0;
   logic [31:0] rd_data1, rd_data2, alu_result;
   logic        alu_zero, alu_carry;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_regs [16];
   logic [31:0] m_rd1, m_rd2, m_res;
   logic        m_zero, m_carry;

   always #5 clk = ~clk;

   risc_exec_datapath dut (
      .clk(clk), .rst(rst),
      .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_en2(rd_en2), .rd_addr2(rd_addr2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_data1(rd_data1), .rd_data2(rd_data2),
      .npc(npc), .imm(imm), .a_sel(a_sel), .b_sel(b_sel), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic c);
      logic [63:0] wide;
      int sa, sb, sh;
      sa = a; sb = b; sh = int'(b[4:0]);
      c = 1'b0;
      case (op)
         4'd0:  begin wide = 64'(a) + 64'(b); r = wide[31:0]; c = wide[32]; end
         4'd1:  begin r = a - b; c = (a < b); end
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  r = ~(a | b);
         4'd6:  r = ~a;
         4'd7:  r = a << sh;
         4'd8:  r = a >> sh;
         4'd9:  begin r = a >> sh; if (a[31] && sh != 0) r = r | ~(32'hFFFF_FFFF >> sh); end
         4'd10: begin r = a + 1; c = (a == 32'hFFFF_FFFF); end
         4'd11: begin r = a - 1; c = (a == 32'h0); end
         4'd12: r = (sa < sb) ? 32'd1 : 32'd0;
         4'd13: r = (sa > sb) ? 32'd1 : 32'd0;
         4'd14: r = b * 32'd65536;
         default: begin r = 0; for (int i = 0; i < 32; i++) if (a[i]) r = r + 1; end
      endcase
   endfunction

   // Advance one clock: update the model with the pre-edge inputs, then compare at the falling edge.
   task automatic tick();
      logic [31:0] op1, op2, r;
      logic        c;
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 16; i++) m_regs[i] = 0;
         m_rd1 = 0; m_rd2 = 0; m_res = 0; m_zero = 0; m_carry = 0;
      end else begin
         op1 = a_sel ? {22'd0, npc} : m_rd1;
         op2 = b_sel ? imm : m_rd2;
         alu_ref(alu_op, op1, op2, r, c);
         m_res = r; m_zero = (r == 0); m_carry = c;
         if (rd_en1) m_rd1 = (wr_en && wr_addr == rd_addr1) ? wr_data : m_regs[rd_addr1];
         if (rd_en2) m_rd2 = (wr_en && wr_addr == rd_addr2) ? wr_data : m_regs[rd_addr2];
         if (wr_en) m_regs[wr_addr] = wr_data;
      end
      @(negedge clk);
      check("model_rd1", rd_data1, m_rd1);
      check("model_rd2", rd_data2, m_rd2);
      check("model_res", alu_result, m_res);
      check("model_zero", {31'd0, alu_zero}, {31'd0, m_zero});
      check("model_carry", {31'd0, alu_carry}, {31'd0, m_carry});
   endtask

   task automatic idle();
      rd_en1 = 0; rd_en2 = 0; wr_en = 0;
   endtask

   task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
      idle(); wr_en = 1; wr_addr = a; wr_data = d; tick(); idle();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
      m_rd1 = 0; m_rd2 = 0; m_res = 0; m_zero = 0; m_carry = 0;
      @(negedge clk);

      // reset state
      rst = 1; tick();
      check("rst_res", alu_result, 32'h0);
      check("rst_zero", {31'd0, alu_zero}, 32'h0);
      check("rst_carry", {31'd0, alu_carry}, 32'h0);
      rst = 0;
      for (int i = 0; i < 16; i++) begin
         rd_en1 = 1; rd_addr1 = 4'(i); tick();
         check("rst_reg", rd_data1, 32'h0);
      end
      idle();

      // ADD with carry out
      write_reg(4'd3, 32'h0000_0005);
      write_reg(4'd4, 32'hFFFF_FFFE);
      rd_en1 = 1; rd_addr1 = 3; rd_en2 = 1; rd_addr2 = 4; tick(); idle();
      a_sel = 0; b_sel = 0; alu_op = 4'd0; tick();
      check("add_res", alu_result, 32'h0000_0003);
      check("add_carry", {31'd0, alu_carry}, 32'h1);

      // SUB with borrow
      b_sel = 1; imm = 32'hFFFF_FFFF; alu_op = 4'd1; tick();
      check("sub_res", alu_result, 32'h0000_0006);
      check("sub_borrow", {31'd0, alu_carry}, 32'h1);

      // same-edge write and read, then hold
      wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5_0000; rd_en1 = 1; rd_addr1 = 7; tick();
      check("wfirst", rd_data1, 32'hA5A5_0000);
      idle(); tick();
      check("hold", rd_data1, 32'hA5A5_0000);

      // shifts and popcount
      write_reg(4'd1, 32'h8000_0000);
      rd_en1 = 1; rd_addr1 = 1; tick(); idle();
      a_sel = 0; b_sel = 1; imm = 4; alu_op = 4'd9; tick();
      check("sra", alu_result, 32'hF800_0000);
      alu_op = 4'd8; tick();
      check("srl", alu_result, 32'h0800_0000);
      imm = 0; alu_op = 4'd9; tick();
      check("sra0", alu_result, 32'h8000_0000);
      write_reg(4'd2, 32'hF0F0_0001);
      rd_en1 = 1; rd_addr1 = 2; tick(); idle();
      alu_op = 4'd15; tick();
      check("ham", alu_result, 32'd9);

      // PC-relative add
      a_sel = 1; npc = 10'd100; b_sel = 1; imm = 3; alu_op = 4'd0; tick();
      check("npc_add", alu_result, 32'd103);
      a_sel = 0;

      // randomized traffic with occasional reset
      for (int n = 0; n < 400; n++) begin
         rst      = ($urandom_range(0, 49) == 0);
         rd_en1   = ($urandom_range(0, 3) != 0);
         rd_en2   = ($urandom_range(0, 3) != 0);
         wr_en    = ($urandom_range(0, 1) != 0);
         rd_addr1 = 4'($urandom_range(0, 15));
         rd_addr2 = 4'($urandom_range(0, 15));
         wr_addr  = 4'($urandom_range(0, 15));
         wr_data  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         imm      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         npc      = 10'($urandom);
         a_sel    = ($urandom_range(0, 3) == 0);
         b_sel    = ($urandom_range(0, 1) != 0);
         alu_op   = 4'($urandom_range(0, 15));
         tick();
      end
      rst = 0; idle();

      // reset in the middle of activity
      write_reg(4'd9, 32'h1234_5678);
      rd_en1 = 1; rd_addr1 = 9; rd_en2 = 1; rd_addr2 = 9; tick();
      check("pre_rst", rd_data2, 32'h1234_5678);
      alu_op = 4'd6; rst = 1; wr_en = 1; wr_addr = 5; wr_data = 32'hDEAD_BEEF; tick();
      check("mid_rst_rd1", rd_data1, 32'h0);
      check("mid_rst_res", alu_result, 32'h0);
      rst = 0; idle(); rd_en1 = 1; rd_addr1 = 9; rd_en2 = 1; rd_addr2 = 5; tick();
      check("mid_rst_r9", rd_data1, 32'h0);
      check("mid_rst_r5", rd_data2, 32'h0);
      idle(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
